// File: rtl/clk_div_sequencer.sv
// clk_div_sequencer: plays a 4-entry (period, high, dwell) table as a registered divided clock
module clk_div_sequencer #(
  parameter int CNT_W = 16,
  parameter int DW_W  = 8,
  parameter int P0    = 22153,
  parameter int H0    = 4430,
  parameter int D0    = 4,
  parameter int P1    = 4079,
  parameter int H1    = 815,
  parameter int D1    = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [DW_W-1:0]  wr_dwell,
  output logic             clk_out,
  output logic             busy,
  output logic [1:0]       cur_idx,
  output logic             period_tick,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic any_q, any_d, clk_q, clk_d, tick_q, tick_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, ap_q, ap_d, ah_q, ah_d;
  logic [DW_W-1:0] dw_q, dw_d;
  logic [CNT_W-1:0] tp_q [4], tp_d [4], th_q [4], th_d [4];
  logic [DW_W-1:0] td_q [4], td_d [4];
  logic ent_ok, last_cyc, eol;
  assign ent_ok = tp_q[idx_q] >= CNT_W'(2) && th_q[idx_q] < tp_q[idx_q] && td_q[idx_q] != '0;
  assign last_cyc = cnt_q == ap_q - 1'b1;
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      any_q   <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ap_q    <= '0;
      ah_q    <= '0;
      dw_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        tp_q[i] <= i == 0 ? CNT_W'(P0) : i == 1 ? CNT_W'(P1) : '0;
        th_q[i] <= i == 0 ? CNT_W'(H0) : i == 1 ? CNT_W'(H1) : '0;
        td_q[i] <= i == 0 ? DW_W'(D0) : i == 1 ? DW_W'(D1) : '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      any_q   <= any_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ap_q    <= ap_d;
      ah_q    <= ah_d;
      dw_q    <= dw_d;
      tp_q    <= tp_d;
      th_q    <= th_d;
      td_q    <= td_d;
    end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    any_d   = any_q;
    cnt_d   = cnt_q;
    ap_d    = ap_q;
    ah_d    = ah_q;
    dw_d    = dw_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    eol     = 1'b0;
    tp_d    = tp_q;
    th_d    = th_q;
    td_d    = td_q;
    if (wr_en) begin
      tp_d[wr_addr] = wr_period;
      th_d[wr_addr] = wr_high;
      td_d[wr_addr] = wr_dwell;
    end
    case (state_q)
      IDLE: if (start && !stop) begin
        state_d = LOAD;
        idx_d   = '0;
        any_d   = 1'b0;
      end
      LOAD: if (stop) state_d = IDLE;
      else if (ent_ok) begin
        ap_d    = tp_q[idx_q];
        ah_d    = th_q[idx_q];
        dw_d    = td_q[idx_q];
        cnt_d   = '0;
        any_d   = 1'b1;
        state_d = RUN;
      end else if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
      else eol = 1'b1;
      RUN: if (stop) state_d = IDLE;
      else begin
        clk_d = cnt_q < ah_q;
        if (last_cyc) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          dw_d   = dw_q - 1'b1;
          if (dw_q == DW_W'(1)) begin
            if (idx_q != 2'd3) begin
              idx_d   = idx_q + 2'd1;
              state_d = LOAD;
            end else eol = 1'b1;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // an all-invalid pass never sets any_q, so looping cannot spin forever
    if (eol && loop && any_q) begin
      state_d = LOAD;
      idx_d   = '0;
      any_d   = 1'b0;
    end else if (eol) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_comb begin
    clk_out     = clk_q;
    busy        = state_q != IDLE;
    cur_idx     = idx_q;
    period_tick = tick_q;
    done        = done_q;
  end
endmodule

// File: tb/tb_clk_div_sequencer.sv
// tb_clk_div_sequencer: directed checks of table playback, looping, stop, reset and live table writes
module tb_clk_div_sequencer;
  logic clk_in = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [15:0] wr_period = '0, wr_high = '0;
  logic [7:0] wr_dwell = '0;
  logic clk_out, busy, period_tick, done;
  logic [1:0] cur_idx;
  int total = 0, passed = 0, fails = 0;
  int n, hi, tk;
  logic [19:0] pat2;
  logic [24:0] pat6;

  clk_div_sequencer dut (
    .clk_in(clk_in), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period), .wr_high(wr_high),
    .wr_dwell(wr_dwell), .clk_out(clk_out), .busy(busy), .cur_idx(cur_idx),
    .period_tick(period_tick), .done(done)
  );

  always #10 clk_in = ~clk_in;

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] p, input logic [15:0] h, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_period = p; wr_high = h; wr_dwell = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_clk", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", cur_idx, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    step();
    // default entry 0: one full period
    pulse_start();
    chk("t1_busy", busy, 1);
    step();
    n = 0; hi = 0; tk = 0;
    while (tk == 0 && n < 30000) begin
      step(); n++; hi += int'(clk_out); tk = int'(period_tick);
    end
    chk("t1_period", n, 22153);
    chk("t1_high", hi, 4430);
    chk("t1_idx", cur_idx, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t1_stop_busy", busy, 0);
    chk("t1_stop_done", done, 0);
    // default periods with dwell 1: e0, LOAD, e1, two skips, done
    wr(0, 22153, 4430, 1);
    wr(1, 4079, 815, 1);
    pulse_start();
    step();
    n = 0; hi = 0; tk = 0;
    while (done !== 1'b1 && n < 40000) begin
      step(); n++; hi += int'(clk_out); tk += int'(period_tick);
    end
    chk("t1b_cycles", n, 26235);
    chk("t1b_high", hi, 5245);
    chk("t1b_ticks", tk, 2);
    chk("t1b_busy", busy, 0);
    // short table one-shot, with an ignored start while busy
    wr(0, 5, 1, 2);
    wr(1, 0, 0, 0);
    wr(2, 4, 2, 1);
    wr(3, 3, 0, 1);
    loop = 1'b0;
    pulse_start();
    chk("t2_load_clk", clk_out, 0);
    step();
    pat2 = 20'b1000010000_0011000000;
    tk = 0;
    for (int k = 0; k < 20; k++) begin
      start = (k == 2);
      step();
      chk($sformatf("t2_clk%0d", k), clk_out, pat2[19-k]);
      tk += int'(period_tick);
      if (k == 18) chk("t2_done_early", done, 0);
    end
    start = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_ticks", tk, 4);
    chk("t2_idx_hold", cur_idx, 3);
    step();
    chk("t2_done_pulse", done, 0);
    // same table looping, stop in e0 high phase of second pass
    loop = 1'b1;
    pulse_start();
    step();
    step(10); chk("t3_idx1", cur_idx, 1);
    step();   chk("t3_idx2", cur_idx, 2);
    step(5);  chk("t3_idx3", cur_idx, 3);
    step(4);
    chk("t3_wrap_idx", cur_idx, 0);
    chk("t3_wrap_busy", busy, 1);
    chk("t3_wrap_done", done, 0);
    step(2);
    chk("t3_high", clk_out, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t3_stop_clk", clk_out, 0);
    chk("t3_stop_busy", busy, 0);
    chk("t3_stop_done", done, 0);
    step();
    chk("t3_no_done", done, 0);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("t3_start_stop", busy, 0);
    // every entry invalid for a different reason
    wr(0, 1, 0, 1);
    wr(2, 4, 4, 1);
    wr(3, 3, 0, 0);
    pulse_start();
    step(3);
    chk("t4_busy", busy, 1);
    chk("t4_idx", cur_idx, 3);
    chk("t4_clk", clk_out, 0);
    step();
    chk("t4_end_busy", busy, 0);
    chk("t4_done", done, 1);
    chk("t4_end_clk", clk_out, 0);
    step();
    chk("t4_done_pulse", done, 0);
    // rewrite the running entry mid-dwell
    wr(0, 5, 1, 3);
    pulse_start();
    step();
    pat6 = 25'b10000_10000_10000_0000_111000;
    for (int k = 0; k < 25; k++) begin
      if (k == 6) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_period = 16'd6; wr_high = 16'd3; wr_dwell = 8'd1;
      end
      if (k == 7) wr_en = 1'b0;
      step();
      chk($sformatf("t6_clk%0d", k), clk_out, pat6[24-k]);
      if (k == 14 || k == 23 || k == 24) chk($sformatf("t6_tick%0d", k), period_tick, k != 23);
    end
    chk("t6_idx", cur_idx, 1);
    stop = 1'b1; step(); stop = 1'b0;
    // async reset in entry 1, then table defaults
    wr(0, 5, 1, 1);
    wr(1, 20, 5, 2);
    loop = 1'b0;
    pulse_start();
    step(10);
    chk("t5_idx_pre", cur_idx, 1);
    chk("t5_clk_pre", clk_out, 1);
    #5 rst = 1'b0;
    #1;
    chk("t5_rst_clk", clk_out, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_idx", cur_idx, 0);
    #3 rst = 1'b1;
    step();
    pulse_start();
    step(2);
    hi = 0;
    while (clk_out === 1'b1 && hi < 6000) begin
      hi++; step();
    end
    chk("t5_default_high", hi, 4430);
    chk("t5_idx", cur_idx, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t5_stop_busy", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/clk_div_sequencer.md
Name: clk_div_sequencer

Overview:
Programmable clock-divider sequencer for the 50 MHz board clock. It holds a 4-entry table of (period, high-time, dwell) settings and drives its own registered divider output `clk_out` through the entries in order. Each entry runs for a programmed number of output periods. The block supports one-shot or looping playback, start/stop control and runtime table writes. It sits between the panel/control logic and the tone/clock output pin.

Parameters:
CNT_W, 16, width of period/high counters
DW_W, 8, width of dwell counter
P0, 22153, reset period of entry 0 in clk_in cycles (50e6/2257)
H0, 4430, reset high time of entry 0 (20% duty)
D0, 4, reset dwell of entry 0 in output periods
P1, 4079, reset period of entry 1 (50e6/12257)
H1, 815, reset high time of entry 1
D1, 4, reset dwell of entry 1

Ports:
clk_in  input  1  system clock, 50 MHz
rst  input  1  reset, asynchronous, active-low
start  input  1  start pulse; sampled only in IDLE
stop  input  1  stop pulse; aborts playback
loop  input  1  level; 1 = wrap from entry 3 back to entry 0
wr_en  input  1  table write strobe
wr_addr  input  2  table entry index
wr_period  input  CNT_W  period value to write
wr_high  input  CNT_W  high-time value to write
wr_dwell  input  DW_W  dwell value to write
clk_out  output  1  divided clock, registered
busy  output  1  1 while not IDLE
cur_idx  output  2  entry currently loaded or running
period_tick  output  1  1-cycle pulse on the last cycle of each output period
done  output  1  1-cycle pulse on natural end of sequence

Behaviour:
- Reset (rst=0, async): state=IDLE; clk_out, busy, cur_idx, period_tick, done = 0; counters = 0.
- Table reset: entry0=(P0,H0,D0), entry1=(P1,H1,D1), entries 2 and 3 = (0,0,0).
- Entry valid iff period>=2, high<period and dwell>=1. high=0 is legal and gives a constant-low period.
- States: IDLE, LOAD, RUN.
- IDLE: clk_out=0.
  - start=1 and stop=0: idx<=0, any_valid<=0, go to LOAD.
  - start and stop in the same cycle: stay in IDLE.
- LOAD (exactly 1 cycle, clk_out<=0):
  - Valid entry[idx]: latch period/high/dwell into active registers, cnt<=0, any_valid<=1, go to RUN.
  - Invalid entry, idx<3: idx<=idx+1, remain in LOAD.
  - Invalid entry, idx==3: apply end-of-list rule.
- RUN, every cycle:
  - clk_out<=(cnt<act_high).
  - If cnt==act_period-1: cnt<=0, period_tick=1, dwell_cnt<=dwell_cnt-1.
    - If dwell_cnt==1: leave the entry. idx<3 → idx+1 and go to LOAD; idx==3 → end-of-list rule.
  - Otherwise cnt<=cnt+1.
- End-of-list rule:
  - loop=1 and any_valid=1: idx<=0, any_valid<=0, go to LOAD.
  - Otherwise: go to IDLE with done=1 for one cycle.
  - An all-invalid table therefore terminates even with loop=1.
- Timing:
  - First clk_out rise is 2 edges after the edge sampling start (start→LOAD→RUN).
  - Every entry transition and every skipped invalid entry inserts one LOAD cycle with clk_out=0; this extends the low phase.
  - Within RUN: exactly act_high cycles high, then act_period-act_high cycles low.
- stop=1 in LOAD or RUN: next edge goes to IDLE with clk_out=0 and busy=0. No done pulse. stop has priority over all other events.
- start while busy: ignored.
- Table writes:
  - Take effect the edge after wr_en and are allowed in any state.
  - A write to the running entry does not alter the active registers; the new value is used at that entry's next LOAD.
- cur_idx = idx, held at its last value in IDLE.
- busy = (state != IDLE), registered with the state.
- Counter arithmetic is unsigned with no wrap. cnt never exceeds act_period-1.

Test Plan:
1. Reset, loop=0, pulse start → 4 periods of 22153 cycles (4430 high), 1 LOAD cycle, 4 periods of 4079 (815 high), 2 skip cycles, done pulse, busy=0; 8 period_ticks total.
2. Write e0=(5,1,2), e1=(0,0,0), e2=(4,2,1), e3=(3,0,1); start, loop=0 → clk_out after LOAD: 1000010000, then low LOAD, low skip, 1100, low LOAD, 000; done one cycle after the last period.
3. Same table, loop=1 → cur_idx sequence 0,1,2,3,0…; assert stop mid-e0 high phase → clk_out=0 and busy=0 next edge, no done.
4. All entries written invalid, loop=1, start → 4 LOAD cycles, then IDLE with done=1 once; clk_out stays 0.
5. Pulse rst low mid-RUN of entry 1 → all outputs 0 immediately; table back to defaults (e0 period reads 22153 on next run).
6. Loop running e0=(5,1,3); write e0=(6,3,1) during its second period → remainder of the current dwell keeps period 5; the next pass uses period 6, high 3, dwell 1.
